demux_stream: RTL and testbench

Registered, parametrised 1-to-CH stream demultiplexer with valid/ready handshake on the input and on every output channel. Each accepted input word is steered by a select field to one output channel, or copied to all channels in broadcast mode, and is held in that channel's one-entry output register until the channel's consumer takes it. It is the clocked, back-pressure-aware successor to the team's combinational 4-channel demux and sits between a single producer and CH independent consumers.

---
 rtl/demux_stream.sv | 85 ++++++++
 tb/tb_demux_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// Registered 1-to-CH stream demultiplexer with per-channel one-entry holding registers.
// Words are steered by in_sel or broadcast to all channels; out-of-range selects are dropped and flagged.
module demux_stream #(
    parameter int WIDTH = 4,
    parameter int CH    = 4,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SELW-1:0]       in_sel,
    input  logic                  in_bcast,
    output logic [CH-1:0]         out_valid,
    input  logic [CH-1:0]         out_ready,
    output logic [CH*WIDTH-1:0]   out_data,
    output logic                  sel_err
);

    localparam logic [SELW:0] CH_L = CH[SELW:0];

    logic [CH-1:0]    vld_p0;
    logic [WIDTH-1:0] data_p0 [CH];
    logic             sel_err_p0;

    logic [CH-1:0]    can_acc;
    logic [CH-1:0]    load;
    logic             sel_ok;
    logic             sel_can_acc;
    logic             accept;

    assign can_acc = ~vld_p0 | out_ready;
    assign sel_ok  = ({1'b0, in_sel} < CH_L);

    // Loop instead of can_acc[in_sel] so an out-of-range select never indexes past the vector.
    always_comb begin
        sel_can_acc = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (in_sel == SELW'(k)) sel_can_acc = can_acc[k];
        end
    end

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast)    in_ready = &can_acc;
        else if (sel_ok) in_ready = sel_can_acc;
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < CH; k++) begin
            load[k] = accept & (in_bcast | (sel_ok & (in_sel == SELW'(k))));
        end
    end

    // Stage p0: per-channel holding registers; a load on the draining edge wins.
    for (genvar k = 0; k < CH; k++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p0[k]  <= 1'b0;
                data_p0[k] <= '0;
            end else if (load[k]) begin
                vld_p0[k]  <= 1'b1;
                data_p0[k] <= in_data;
            end else if (vld_p0[k] && out_ready[k]) begin
                vld_p0[k]  <= 1'b0;
                data_p0[k] <= '0;
            end
        end

        assign out_data[k*WIDTH +: WIDTH] = vld_p0[k] ? data_p0[k] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err_p0 <= 1'b0;
        else        sel_err_p0 <= accept & ~in_bcast & ~sel_ok;
    end

    assign out_valid = vld_p0;
    assign sel_err   = sel_err_p0;

endmodule

// File: tb/tb_demux_stream.sv
// Directed and randomised checks of demux_stream with CH=4, plus a CH=3 instance for out-of-range selects.
module tb_demux_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_bcast, a_sel_err;
    logic [3:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [15:0] a_out_data;

    logic        b_in_valid, b_in_ready, b_in_bcast, b_sel_err;
    logic [3:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [11:0] b_out_data;

    int checks = 0;
    int errors = 0;

    demux_stream #(.WIDTH(4), .CH(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_sel(a_in_sel), .in_bcast(a_in_bcast),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .sel_err(a_sel_err)
    );

    demux_stream #(.WIDTH(4), .CH(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_bcast(b_in_bcast),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .sel_err(b_sel_err)
    );

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 4'hA; a_out_ready = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 4'b0100) begin
            errors++; $display("FAIL reset_preload out_valid=%b expected=%b", a_out_valid, 4'b0100);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 16'h0) begin
            errors++; $display("FAIL reset_outputs out_valid=%b out_data=%h expected 0000/0000", a_out_valid, a_out_data);
        end
        checks++;
        if (a_in_ready !== 1'b1 || a_sel_err !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready in_ready=%b sel_err=%b b_in_ready=%b expected 1/0/1", a_in_ready, a_sel_err, b_in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unicast();
        logic [15:0] exp_d;
        a_out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_bcast = 1'b0; a_in_sel = 2'(i); a_in_data = 4'(i + 1);
            #1;
            checks++;
            if (a_in_ready !== 1'b1) begin
                errors++; $display("FAIL unicast_ready word=%0d in_ready=%b expected=1", i, a_in_ready);
            end
            @(posedge clk); #1;
            exp_d = 16'(i + 1) << (4 * i);
            checks++;
            if (a_out_valid !== 4'(1 << i) || a_out_data !== exp_d) begin
                errors++; $display("FAIL unicast_out word=%0d out_valid=%b out_data=%h expected %b/%h",
                                   i, a_out_valid, a_out_data, 4'(1 << i), exp_d);
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 16'h0) begin
            errors++; $display("FAIL unicast_drain out_valid=%b out_data=%h expected 0000/0000", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a_out_ready = 4'b1101;
        a_in_valid = 1'b1; a_in_bcast = 1'b0; a_in_sel = 2'd1; a_in_data = 4'h5;
        @(posedge clk);
        @(negedge clk);
        a_in_data = 4'h6;
        #1;
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 4'b0010 || a_out_data !== 16'h0050) begin
            errors++; $display("FAIL bp_stall in_ready=%b out_valid=%b out_data=%h expected 0/0010/0050",
                               a_in_ready, a_out_valid, a_out_data);
        end
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (a_in_ready !== 1'b0 || a_out_data !== 16'h0050) begin
            errors++; $display("FAIL bp_hold in_ready=%b out_data=%h expected 0/0050", a_in_ready, a_out_data);
        end
        a_out_ready = 4'b1111;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release in_ready=%b expected=1", a_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 4'b0010 || a_out_data !== 16'h0060) begin
            errors++; $display("FAIL bp_swap out_valid=%b out_data=%h expected 0010/0060", a_out_valid, a_out_data);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 4'b0000) begin
            errors++; $display("FAIL bp_empty out_valid=%b expected=0000", a_out_valid);
        end
    endtask

    task automatic test_broadcast();
        @(negedge clk);
        a_out_ready = 4'b0111;
        a_in_valid = 1'b1; a_in_bcast = 1'b0; a_in_sel = 2'd3; a_in_data = 4'h9;
        @(posedge clk);
        @(negedge clk);
        a_in_bcast = 1'b1; a_in_sel = 2'd1; a_in_data = 4'hC;
        #1;
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 4'b1000 || a_out_data !== 16'h9000) begin
            errors++; $display("FAIL bcast_stall in_ready=%b out_valid=%b out_data=%h expected 0/1000/9000",
                               a_in_ready, a_out_valid, a_out_data);
        end
        @(posedge clk);
        @(negedge clk);
        a_out_ready = 4'b1111;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++; $display("FAIL bcast_release in_ready=%b expected=1", a_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 4'b1111 || a_out_data !== 16'hCCCC || a_sel_err !== 1'b0) begin
            errors++; $display("FAIL bcast_out out_valid=%b out_data=%h sel_err=%b expected 1111/cccc/0",
                               a_out_valid, a_out_data, a_sel_err);
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_in_bcast = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 16'h0) begin
            errors++; $display("FAIL bcast_drain out_valid=%b out_data=%h expected 0000/0000", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        b_out_ready = 3'b111;
        b_in_valid = 1'b1; b_in_bcast = 1'b0; b_in_sel = 2'd3; b_in_data = 4'h7;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++; $display("FAIL oor_ready in_ready=%b expected=1", b_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (b_sel_err !== 1'b1 || b_out_valid !== 3'b000 || b_out_data !== 12'h0) begin
            errors++; $display("FAIL oor_drop sel_err=%b out_valid=%b out_data=%h expected 1/000/000",
                               b_sel_err, b_out_valid, b_out_data);
        end
        @(negedge clk);
        b_in_sel = 2'd2; b_in_data = 4'h5;
        @(posedge clk); #1;
        checks++;
        if (b_sel_err !== 1'b0 || b_out_valid !== 3'b100 || b_out_data !== 12'h500) begin
            errors++; $display("FAIL oor_inrange sel_err=%b out_valid=%b out_data=%h expected 0/100/500",
                               b_sel_err, b_out_valid, b_out_data);
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (b_sel_err !== 1'b0 || b_out_valid !== 3'b000) begin
            errors++; $display("FAIL oor_idle sel_err=%b out_valid=%b expected 0/000", b_sel_err, b_out_valid);
        end
    endtask

    task automatic test_random();
        logic       occ [4];
        logic [3:0] val [4];
        logic       exp_rdy, acc, bad;
        logic [3:0] exp_v;
        logic [15:0] exp_d;
        int         shown = 0;
        for (int k = 0; k < 4; k++) begin
            occ[k] = 1'b0; val[k] = 4'h0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_bcast  = ($urandom_range(0, 7) == 0);
            a_in_sel    = 2'($urandom_range(0, 3));
            a_in_data   = 4'($urandom_range(0, 15));
            a_out_ready = 4'($urandom_range(0, 15));
            #1;
            exp_v = 4'h0; exp_d = 16'h0;
            for (int k = 0; k < 4; k++) begin
                exp_v[k] = occ[k];
                if (occ[k]) exp_d[k*4 +: 4] = val[k];
            end
            if (a_in_bcast) begin
                exp_rdy = 1'b1;
                for (int k = 0; k < 4; k++) if (occ[k] && !a_out_ready[k]) exp_rdy = 1'b0;
            end else begin
                exp_rdy = !occ[a_in_sel] || a_out_ready[a_in_sel];
            end
            bad = (a_in_ready !== exp_rdy) || (a_out_valid !== exp_v) || (a_out_data !== exp_d) || (a_sel_err !== 1'b0);
            checks++;
            if (bad) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cycle=%0d in_ready=%b out_valid=%b out_data=%h expected %b/%b/%h",
                             c, a_in_ready, a_out_valid, a_out_data, exp_rdy, exp_v, exp_d);
                end
            end
            acc = a_in_valid && exp_rdy;
            for (int k = 0; k < 4; k++) begin
                if (occ[k] && a_out_ready[k]) occ[k] = 1'b0;
                if (acc && (a_in_bcast || a_in_sel == 2'(k))) begin
                    occ[k] = 1'b1; val[k] = a_in_data;
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 4'b1111;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 4'b0000) begin
            errors++; $display("FAIL random_drain out_valid=%b expected=0000", a_out_valid);
        end
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_bcast = 1'b0; a_in_sel = 2'd0; a_in_data = 4'h0; a_out_ready = 4'h0;
        b_in_valid = 1'b0; b_in_bcast = 1'b0; b_in_sel = 2'd0; b_in_data = 4'h0; b_out_ready = 3'h0;
        repeat (3) @(posedge clk);
        test_reset();
        test_unicast();
        test_back_to_back();
        test_broadcast();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
